// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the width rule for the shared cycle counter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HOLD     = 3'd1,
    ST_REL_CORE = 3'd2,
    ST_RUN      = 3'd3
  } state_e;

  function automatic int cnt_width(input int hold_c, input int gap_c, input int wdog_c);
    int m;
    m = hold_c;
    if (gap_c > m) m = gap_c;
    if (wdog_c > m) m = wdog_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asynchronous assertion, deassertion after STAGES
// rising clk edges.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds core/tx resets after a synchronized release, then
// releases core first and tx last. Optional watchdog: define RST_SEQ_WDOG_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 16,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_req,
  input  logic       wdog_kick,
  output logic       rst_n_sync,
  output logic       core_rst,
  output logic       tx_rst,
  output logic       ready,
  output logic       wdog_trip,
  output logic [2:0] state
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("rst_seq: SYNC_STAGES must be in 2..4");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq: HOLD_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("rst_seq: GAP_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("rst_seq: WDOG_CYCLES must be at least 1");
  end

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, WDOG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef RST_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
`endif

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst),
    .rst_n_sync (rst_n_sync)
  );

  state_e           st, st_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             core_d, tx_d, rdy_d, trip_d, restart;

`ifndef RST_SEQ_WDOG_EN
  logic unused_kick;
  assign unused_kick = wdog_kick;
`endif

  always_comb begin
    st_d    = st;
    cnt_d   = cnt_inc(cnt);
    core_d  = core_rst;
    tx_d    = tx_rst;
    rdy_d   = ready;
    trip_d  = 1'b0;
    restart = 1'b0;
    unique case (st)
      ST_RESET: begin
        cnt_d = '0;
        if (rst_n_sync) st_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (soft_req) begin
          restart = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          st_d   = ST_REL_CORE;
          cnt_d  = '0;
          core_d = 1'b0;
        end
      end
      ST_REL_CORE: begin
        if (soft_req) begin
          restart = 1'b1;
        end else if (cnt == GAP_LAST) begin
          st_d  = ST_RUN;
          cnt_d = '0;
          tx_d  = 1'b0;
          rdy_d = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef RST_SEQ_WDOG_EN
        // A kick on the expiry edge clears the count before expiry is seen.
        if (soft_req) begin
          restart = 1'b1;
        end else if (wdog_kick) begin
          cnt_d = '0;
        end else if (cnt == WDOG_LAST) begin
          restart = 1'b1;
          trip_d  = 1'b1;
        end
`else
        cnt_d = '0;
        if (soft_req) restart = 1'b1;
`endif
      end
      default: begin
        st_d  = ST_RESET;
        cnt_d = '0;
      end
    endcase
    if (restart) begin
      st_d   = ST_HOLD;
      cnt_d  = '0;
      core_d = 1'b1;
      tx_d   = 1'b1;
      rdy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= ST_RESET;
      cnt       <= '0;
      core_rst  <= 1'b1;
      tx_rst    <= 1'b1;
      ready     <= 1'b0;
      wdog_trip <= 1'b0;
    end else begin
      st        <= st_d;
      cnt       <= cnt_d;
      core_rst  <= core_d;
      tx_rst    <= tx_d;
      ready     <= rdy_d;
      wdog_trip <= trip_d;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (SYNC_STAGES=2, HOLD=8, GAP=4, WDOG=32) with
// expectations queued at stimulus time and checked at the due clk edge.
module tb_rst_seq;

  localparam logic [7:0] S_RESET = 8'd0, S_HOLD = 8'd1, S_REL = 8'd2, S_RUN = 8'd3;
  localparam int SEL_SYNC = 0, SEL_CORE = 1, SEL_TX = 2, SEL_RDY = 3, SEL_TRIP = 4, SEL_ST = 5;

  logic       clk, rst, soft_req, wdog_kick;
  logic       rst_n_sync, core_rst, tx_rst, ready, wdog_trip;
  logic [2:0] state;

  rst_seq #(
    .SYNC_STAGES(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .WDOG_CYCLES(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_req   (soft_req),
    .wdog_kick  (wdog_kick),
    .rst_n_sync (rst_n_sync),
    .core_rst   (core_rst),
    .tx_rst     (tx_rst),
    .ready      (ready),
    .wdog_trip  (wdog_trip),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      SEL_SYNC: return {7'd0, rst_n_sync};
      SEL_CORE: return {7'd0, core_rst};
      SEL_TX:   return {7'd0, tx_rst};
      SEL_RDY:  return {7'd0, ready};
      SEL_TRIP: return {7'd0, wdog_trip};
      default:  return {5'd0, state};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, o, e, edge_n);
    end
  endtask

  task automatic expect_at(input int at, input int sel, input logic [7:0] v, input string tag);
    exp_t x;
    x.at_edge = at; x.sel = sel; x.exp = v; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
      while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
        e = sb.pop_front();
        chk(e.tag, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sync"}, obs(SEL_SYNC), 8'd0);
    chk({tag, "_core"}, obs(SEL_CORE), 8'd1);
    chk({tag, "_tx"},   obs(SEL_TX),   8'd1);
    chk({tag, "_rdy"},  obs(SEL_RDY),  8'd0);
    chk({tag, "_trip"}, obs(SEL_TRIP), 8'd0);
    chk({tag, "_st"},   obs(SEL_ST),   S_RESET);
  endtask

  // Full release sequence counted from the rising edge of rst just before edge b+1.
  task automatic push_powerup(input int b, input string p);
    expect_at(b + 1,  SEL_SYNC, 8'd0,   {p, "_sync_e1"});
    expect_at(b + 2,  SEL_SYNC, 8'd1,   {p, "_sync_e2"});
    expect_at(b + 2,  SEL_ST,   S_RESET, {p, "_st_e2"});
    expect_at(b + 3,  SEL_ST,   S_HOLD, {p, "_st_e3"});
    expect_at(b + 10, SEL_CORE, 8'd1,   {p, "_core_e10"});
    expect_at(b + 11, SEL_CORE, 8'd0,   {p, "_core_e11"});
    expect_at(b + 11, SEL_TX,   8'd1,   {p, "_tx_e11"});
    expect_at(b + 11, SEL_ST,   S_REL,  {p, "_st_e11"});
    expect_at(b + 14, SEL_RDY,  8'd0,   {p, "_rdy_e14"});
    expect_at(b + 15, SEL_RDY,  8'd1,   {p, "_rdy_e15"});
    expect_at(b + 15, SEL_TX,   8'd0,   {p, "_tx_e15"});
    expect_at(b + 15, SEL_ST,   S_RUN,  {p, "_st_e15"});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int k_last;
    rst = 1'b0; soft_req = 1'b0; wdog_kick = 1'b0;

    // Held in reset; soft_req must be ignored.
    tick(3);
    chk_reset_values("rst_hold");
    soft_req = 1'b1;
    tick(2);
    soft_req = 1'b0;
    chk_reset_values("rst_softreq");

    // Power-up release.
    rst = 1'b1;
    b = edge_n;
    push_powerup(b, "pwr");
    tick(16);

    // Soft request in RUN.
    b = edge_n;
    soft_req = 1'b1;
    expect_at(b + 1,  SEL_CORE, 8'd1,  "soft_core_set");
    expect_at(b + 1,  SEL_TX,   8'd1,  "soft_tx_set");
    expect_at(b + 1,  SEL_RDY,  8'd0,  "soft_rdy_clr");
    expect_at(b + 1,  SEL_ST,   S_HOLD, "soft_st_hold");
    expect_at(b + 1,  SEL_SYNC, 8'd1,  "soft_sync_kept");
    expect_at(b + 8,  SEL_CORE, 8'd1,  "soft_core_e8");
    expect_at(b + 9,  SEL_CORE, 8'd0,  "soft_core_e9");
    expect_at(b + 12, SEL_RDY,  8'd0,  "soft_rdy_e12");
    expect_at(b + 13, SEL_RDY,  8'd1,  "soft_rdy_e13");
    expect_at(b + 13, SEL_TX,   8'd0,  "soft_tx_e13");
    tick(1);
    soft_req = 1'b0;
    tick(13);

    // Sub-cycle rst glitch while in REL_CORE.
    b = edge_n;
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    tick(8);
    chk("glitch_pre_st", obs(SEL_ST), S_REL);
    #2 rst = 1'b0;
    #1 chk_reset_values("glitch");
    #2 rst = 1'b1;
    b = edge_n;
    push_powerup(b, "glitch");
    tick(16);

    // Repeated soft requests keep HOLD from completing.
    b = edge_n;
    expect_at(b + 1,  SEL_ST,   S_HOLD, "rep_st_hold");
    expect_at(b + 9,  SEL_CORE, 8'd1,  "rep_core_e9");
    expect_at(b + 14, SEL_CORE, 8'd1,  "rep_core_e14");
    expect_at(b + 19, SEL_CORE, 8'd1,  "rep_core_e19");
    expect_at(b + 23, SEL_CORE, 8'd1,  "rep_core_e23");
    expect_at(b + 24, SEL_CORE, 8'd0,  "rep_core_e24");
    expect_at(b + 28, SEL_RDY,  8'd1,  "rep_rdy_e28");
    for (int i = 0; i < 4; i++) begin
      soft_req = 1'b1;
      tick(1);
      soft_req = 1'b0;
      tick(4);
    end
    tick(9);

`ifdef RST_SEQ_WDOG_EN
    // No kick: trip 32 edges after entering RUN at b+28.
    b = b + 28;
    expect_at(b + 31, SEL_TRIP, 8'd0,  "wd_trip_e31");
    expect_at(b + 31, SEL_RDY,  8'd1,  "wd_rdy_e31");
    expect_at(b + 32, SEL_TRIP, 8'd1,  "wd_trip_e32");
    expect_at(b + 32, SEL_RDY,  8'd0,  "wd_rdy_e32");
    expect_at(b + 32, SEL_ST,   S_HOLD, "wd_st_e32");
    expect_at(b + 33, SEL_TRIP, 8'd0,  "wd_trip_e33");
    expect_at(b + 40, SEL_CORE, 8'd0,  "wd_core_e40");
    expect_at(b + 44, SEL_RDY,  8'd1,  "wd_rdy_e44");
    tick(45 - (edge_n - b));

    // Regular kicks: no trip.
    k_last = edge_n;
    for (int i = 0; i < 5; i++) begin
      wdog_kick = 1'b1;
      tick(1);
      k_last = edge_n;
      wdog_kick = 1'b0;
      expect_at(k_last + 19, SEL_RDY,  8'd1, "kick_rdy");
      expect_at(k_last + 19, SEL_TRIP, 8'd0, "kick_trip");
      tick(19);
    end

    // Kick on the expiry edge wins.
    tick(12);
    wdog_kick = 1'b1;
    expect_at(k_last + 32, SEL_TRIP, 8'd0, "race_trip_e32");
    expect_at(k_last + 32, SEL_RDY,  8'd1, "race_rdy_e32");
    expect_at(k_last + 63, SEL_RDY,  8'd1, "race_rdy_e63");
    expect_at(k_last + 64, SEL_TRIP, 8'd1, "race_trip_e64");
    expect_at(k_last + 65, SEL_TRIP, 8'd0, "race_trip_e65");
    tick(1);
    wdog_kick = 1'b0;
    tick(33);
`else
    // Watchdog absent: kicks and long idle change nothing.
    for (int i = 0; i < 3; i++) begin
      wdog_kick = 1'b1;
      tick(1);
      wdog_kick = 1'b0;
      expect_at(edge_n + 19, SEL_RDY,  8'd1, "nowd_kick_rdy");
      expect_at(edge_n + 19, SEL_TRIP, 8'd0, "nowd_kick_trip");
      tick(19);
    end
    expect_at(edge_n + 40, SEL_RDY,  8'd1,  "nowd_idle_rdy");
    expect_at(edge_n + 40, SEL_TRIP, 8'd0,  "nowd_idle_trip");
    expect_at(edge_n + 40, SEL_ST,   S_RUN, "nowd_idle_st");
    tick(40);
`endif

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
- REQ-001 Parameter: SYNC_STAGES, 2, depth of the reset-deassertion synchronizer; legal values are 2 to 4.
- REQ-002 Parameter: HOLD_CYCLES, 1024, number of clk cycles both resets stay asserted after the synchronized release; must be at least 1.
- REQ-003 Parameter: GAP_CYCLES, 16, number of cycles between core_rst release and tx_rst release; must be at least 1.
- REQ-004 Parameter: WDOG_CYCLES, 65536, watchdog timeout in cycles; used only when RST_SEQ_WDOG_EN is defined.
- REQ-005 Port: clk  input  1  the single clock; the block has no other clock.
- REQ-006 Port: rst  input  1  reset, asynchronous and active-low; typically driven by PLL lock.
- REQ-007 Port: soft_req  input  1  synchronous soft-reset request, sampled each clk edge.
- REQ-008 Port: wdog_kick  input  1  synchronous watchdog restart pulse.
- REQ-009 Port: rst_n_sync  output  1  rst with asynchronous assertion and synchronized deassertion.
- REQ-010 Port: core_rst  output  1  active-high reset for the core domain; released first.
- REQ-011 Port: tx_rst  output  1  active-high reset for the transmitter datapath; released last.
- REQ-012 Port: ready  output  1  high only in state RUN.
- REQ-013 Port: wdog_trip  output  1  one-cycle pulse when the watchdog expires.
- REQ-014 Port: state  output  3  current FSM state, for debug.

Function
- REQ-015 FSM states shall be RESET, HOLD, REL_CORE and RUN; all outputs are registered.
- REQ-016 rst_n_sync shall go high on the SYNC_STAGES-th rising clk edge after rst rises.
- REQ-017 RESET shall move to HOLD on the first edge where rst_n_sync is high; the counter is cleared on entry.
- REQ-018 HOLD shall count HOLD_CYCLES edges, then move to REL_CORE; core_rst goes 0 on that same edge and the counter is cleared.
- REQ-019 REL_CORE shall count GAP_CYCLES edges, then move to RUN; tx_rst goes 0 and ready goes 1 on that same edge.
- REQ-020 soft_req=1 in REL_CORE or RUN shall, on the next edge, set core_rst=1, tx_rst=1, ready=0, enter HOLD and clear the counter.
- REQ-021 soft_req=1 in HOLD shall restart the counter; soft_req in RESET shall be ignored.
- REQ-022 The counter width shall be clog2(max(HOLD_CYCLES, GAP_CYCLES, WDOG_CYCLES)+1); the counter shall saturate and never wrap.
- REQ-023 Illegal parameter values shall cause an elaboration-time error.

Reset
- REQ-024 rst low shall asynchronously force: state=RESET, rst_n_sync=0, core_rst=1, tx_rst=1, ready=0, wdog_trip=0, all counters=0.
- REQ-025 An rst low pulse of any width, including sub-cycle, in any state shall restart the full sequence from RESET.
- REQ-026 soft_req shall never affect rst_n_sync.

Configuration
- REQ-027 With RST_SEQ_WDOG_EN defined: a watchdog counter runs only in RUN and is cleared by wdog_kick.
- REQ-028 With RST_SEQ_WDOG_EN defined: when the watchdog counter reaches WDOG_CYCLES, the block pulses wdog_trip for one cycle and behaves exactly as for soft_req.
- REQ-029 With RST_SEQ_WDOG_EN defined: wdog_kick and the watchdog expiry on the same edge shall resolve as kick wins.
- REQ-030 Without RST_SEQ_WDOG_EN: wdog_kick is ignored and wdog_trip is tied 0; both ports remain present.

Structure
- REQ-031 Package rst_seq_pkg shall hold the state enumeration (3-bit encoding) and the counter-width function.
- REQ-032 Sub-module rst_sync shall implement the SYNC_STAGES-flop async-assert/sync-deassert synchronizer.

Verification (SYNC_STAGES=2, HOLD_CYCLES=8, GAP_CYCLES=4, WDOG_CYCLES=32)
- REQ-033 Power-up: rst rises -> rst_n_sync high at edge 2, core_rst low at edge 11, tx_rst low and ready high at edge 15.
- REQ-034 soft_req pulse in RUN -> next edge: core_rst=1, tx_rst=1, ready=0; core_rst releases 8 edges later and ready returns 4 edges after that.
- REQ-035 rst low for 0.3 cycle during REL_CORE -> immediate RESET with all outputs at reset values, then the full 15-edge sequence.
- REQ-036 soft_req repeated every 5 cycles in HOLD -> core_rst never releases until the requests stop, then releases 8 edges after the last request.
- REQ-037 With RST_SEQ_WDOG_EN and no kick for 32 cycles in RUN -> wdog_trip pulses once and the sequence restarts from HOLD; kicking every 20 cycles -> no trip.
